// File: rtl/la_crc16_engine.sv
// la_crc16_engine
// Streams 32-bit words from the logic-analyzer probes, using a toggle
// req/ack handshake, and folds 1 to 4 bytes per word into a CRC-16.
// One byte is folded per clock, MSB byte first.
// The pads show 0 when idle, a busy pattern while armed or shifting,
// and the final CRC once the last word has been folded.
// The CRC, status bits, ack toggle and word count are mirrored back on the
// LA outputs.
//
// All outputs are registers. They are loaded from the next-state values, so
// they track the internal state registers with no extra cycle of lag.
// Reset forces them to zero at once.

module la_crc16_engine #(
    parameter logic [15:0] CRC_POLY     = 16'h1021,
    parameter logic [15:0] CRC_INIT     = 16'hFFFF,
    parameter logic [15:0] BUSY_PATTERN = 16'hAAAA
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [63:0] la_data_in,
    input  logic [63:0] la_oenb,
    output logic [63:0] la_data_out,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Folds one byte into the CRC, MSB-first, with eight unrolled shift/XOR steps.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in ^ {data_in, 8'h00};
        for (int k = 0; k < 8; k++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    // State registers
    logic [1:0]  r_state;
    logic [15:0] r_crc;
    logic [7:0]  r_count;
    logic        r_done;
    logic        r_ack;
    logic [31:0] r_word;
    logic [1:0]  r_nb_m1;
    logic [1:0]  r_idx;
    logic        r_last;
    logic        r_start_d;
    logic        r_clear_d;
    logic [15:0] r_io_out;
    logic [26:0] r_la_out;

    // Next-state values
    logic [1:0]  w_state_nx;
    logic [15:0] w_crc_nx;
    logic [7:0]  w_count_nx;
    logic        w_done_nx;
    logic        w_ack_nx;
    logic [31:0] w_word_nx;
    logic [1:0]  w_nb_m1_nx;
    logic [1:0]  w_idx_nx;
    logic        w_last_nx;
    logic        w_busy_nx;
    logic [15:0] w_io_nx;

    // Decoded inputs
    logic [37:0] w_eff;
    logic        w_start_edge;
    logic        w_clear_edge;
    logic        w_new_req;
    logic        w_unused_bits;

    // A probe bit counts only while management has it enabled (oenb low).
    assign w_eff         = la_data_in[37:0] & ~la_oenb[37:0];
    assign w_unused_bits = ^{la_data_in[63:38], la_oenb[63:38]};

    assign w_start_edge = w_eff[32] & ~r_start_d;
    assign w_clear_edge = w_eff[37] & ~r_clear_d;
    // Comparing the toggle against our own ack means that a toggle arriving
    // mid-shift stays pending until the block is armed again.
    assign w_new_req    = (w_eff[33] != r_ack);

    assign io_oeb      = 16'h0000;
    assign io_out      = r_io_out;
    assign la_data_out = {37'd0, r_la_out};

    // Next-state logic.
    // Clear beats start, and start re-arms from any state.
    always_comb begin
        w_state_nx = r_state;
        w_crc_nx   = r_crc;
        w_count_nx = r_count;
        w_done_nx  = r_done;
        w_ack_nx   = r_ack;
        w_word_nx  = r_word;
        w_nb_m1_nx = r_nb_m1;
        w_idx_nx   = r_idx;
        w_last_nx  = r_last;
        if (w_clear_edge) begin
            w_state_nx = ST_IDLE;
            w_crc_nx   = CRC_INIT;
            w_count_nx = 8'd0;
            w_done_nx  = 1'b0;
        end else if (w_start_edge) begin
            w_state_nx = ST_ARMED;
            w_crc_nx   = CRC_INIT;
            w_count_nx = 8'd0;
            w_done_nx  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_IDLE;
                end
                ST_ARMED: begin
                    if (w_new_req) begin
                        w_word_nx  = w_eff[31:0];
                        w_nb_m1_nx = w_eff[35:34];
                        w_last_nx  = w_eff[36];
                        w_ack_nx   = w_eff[33];
                        w_count_nx = (r_count == 8'd255) ? 8'd255 : (r_count + 8'd1);
                        w_idx_nx   = 2'd0;
                        w_state_nx = ST_SHIFT;
                    end else begin
                        w_state_nx = ST_ARMED;
                    end
                end
                ST_SHIFT: begin
                    w_crc_nx  = crc16_byte(r_crc, r_word[31:24]);
                    w_word_nx = {r_word[23:0], 8'h00};
                    if (r_idx == r_nb_m1) begin
                        w_state_nx = r_last ? ST_DONE : ST_ARMED;
                        w_done_nx  = r_last;
                    end else begin
                        w_idx_nx = r_idx + 2'd1;
                    end
                end
                ST_DONE: begin
                    w_state_nx = ST_DONE;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Pad and status values for the state being entered.
    always_comb begin
        w_io_nx   = 16'h0000;
        w_busy_nx = 1'b0;
        case (w_state_nx)
            ST_IDLE: begin
                w_io_nx   = 16'h0000;
                w_busy_nx = 1'b0;
            end
            ST_ARMED, ST_SHIFT: begin
                w_io_nx   = BUSY_PATTERN;
                w_busy_nx = 1'b1;
            end
            ST_DONE: begin
                w_io_nx   = w_crc_nx;
                w_busy_nx = 1'b0;
            end
            default: begin
                w_io_nx   = 16'h0000;
                w_busy_nx = 1'b0;
            end
        endcase
    end

    // State, edge-detect history and output registers.
    // Reset asserts asynchronously, so an in-flight word leaves no partial output.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_crc     <= CRC_INIT;
            r_count   <= 8'd0;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
            r_word    <= 32'd0;
            r_nb_m1   <= 2'd0;
            r_idx     <= 2'd0;
            r_last    <= 1'b0;
            r_start_d <= 1'b0;
            r_clear_d <= 1'b0;
            r_io_out  <= 16'h0000;
            r_la_out  <= 27'd0;
        end else begin
            r_state   <= w_state_nx;
            r_crc     <= w_crc_nx;
            r_count   <= w_count_nx;
            r_done    <= w_done_nx;
            r_ack     <= w_ack_nx;
            r_word    <= w_word_nx;
            r_nb_m1   <= w_nb_m1_nx;
            r_idx     <= w_idx_nx;
            r_last    <= w_last_nx;
            r_start_d <= w_eff[32];
            r_clear_d <= w_eff[37];
            r_io_out  <= w_io_nx;
            r_la_out  <= {w_count_nx, w_ack_nx, w_done_nx, w_busy_nx, w_crc_nx};
        end
    end

endmodule

// File: tb/tb_la_crc16_engine.sv
// Scoreboard bench for la_crc16_engine.
// Each stream pushes its expected CRC and word count into a queue when it is
// issued. A monitor pops one entry every time the DUT raises done.
// The reference CRC is a bit-serial polynomial division over the message bits.

module tb_la_crc16_engine;

    localparam logic [15:0] POLY = 16'h1021;

    logic        clk;
    logic        rst;
    logic [63:0] la_in;
    logic [63:0] oenb;
    logic [63:0] la_out;
    logic [15:0] io_out;
    logic [15:0] io_oeb;

    la_crc16_engine dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .la_data_in (la_in),
        .la_oenb    (oenb),
        .la_data_out(la_out),
        .io_out     (io_out),
        .io_oeb     (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] crc;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        req    = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] st_w[8];
    logic [1:0]  st_nb[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: bit-serial division, one message bit at a time.
    function automatic logic [15:0] ref_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = c << 1;
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] c_in, input logic [31:0] w,
                                             input logic [1:0] nb_m1);
        logic [15:0] c;
        c = c_in;
        for (int j = 0; j <= int'(nb_m1); j++) begin
            c = ref_byte(c, w[31-8*j -: 8]);
        end
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        la_in[32] = 1'b1;
        tick();
        la_in[32] = 1'b0;
        tick();
    endtask

    task automatic pulse_clear();
        la_in[37] = 1'b1;
        tick();
        la_in[37] = 1'b0;
        tick();
    endtask

    task automatic set_word(input logic [31:0] w, input logic [1:0] nb, input logic last);
        la_in[31:0]  = w;
        la_in[35:34] = nb;
        la_in[36]    = last;
        req          = ~req;
        la_in[33]    = req;
    endtask

    task automatic wait_ack();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (la_out[18] == req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ack_timeout", {63'd0, la_out[18]}, {63'd0, req});
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (la_out[17]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("done_timeout", {63'd0, la_out[17]}, 64'd1);
    endtask

    // Runs a complete stream of n words from st_w/st_nb.
    task automatic run_stream(input int n);
        logic [15:0] c;
        exp_t        e;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) c = ref_word(c, st_w[i], st_nb[i]);
        e.crc = c;
        e.cnt = (n > 255) ? 8'd255 : 8'(n);
        sb_q.push_back(e);
        pulse_start();
        for (int i = 0; i < n; i++) begin
            set_word(st_w[i], st_nb[i], (i == n - 1));
            wait_ack();
        end
        wait_done();
    endtask

    // Monitor: each rising edge of done is one finished stream.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (la_out[17] && !prev_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("io_crc",   {48'd0, io_out}, {48'd0, e.crc});
                    chk("la_crc",   {48'd0, la_out[15:0]}, {48'd0, e.crc});
                    chk("la_count", {56'd0, la_out[26:19]}, {56'd0, e.cnt});
                    chk("busy_off", {63'd0, la_out[16]}, 64'd0);
                    chk("la_upper", {27'd0, la_out[63:27]}, 64'd0);
                end
            end
            prev_done <= la_out[17];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        la_in = 64'd0;
        oenb  = 64'd0;
        repeat (3) tick();
        chk("rst_io",  {48'd0, io_out}, 64'd0);
        chk("rst_la",  la_out, 64'd0);
        chk("rst_oeb", {48'd0, io_oeb}, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_la", la_out, 64'h0000_0000_0000_FFFF);

        // Every probe disabled: random activity must have no effect.
        oenb = '1;
        for (int i = 0; i < 16; i++) begin
            la_in = {$urandom, $urandom};
            tick();
            chk("oenb_io", {48'd0, io_out}, 64'd0);
            chk("oenb_la", la_out, 64'h0000_0000_0000_FFFF);
        end
        la_in = 64'd0;
        tick();
        oenb = 64'd0;
        tick();
        chk("oenb_io_after", {48'd0, io_out}, 64'd0);

        // Arming state.
        pulse_start();
        chk("arm_io", {48'd0, io_out}, 64'h0000_0000_0000_AAAA);
        chk("arm_la", la_out, 64'h0000_0000_0001_FFFF);

        // "123456789" gives 16'h29B1.
        st_w[0] = 32'h31323334; st_nb[0] = 2'd3;
        st_w[1] = 32'h35363738; st_nb[1] = 2'd3;
        st_w[2] = 32'h39000000; st_nb[2] = 2'd0;
        run_stream(3);
        chk("chk_io",    {48'd0, io_out}, 64'h0000_0000_0000_29B1);
        chk("chk_done",  {63'd0, la_out[17]}, 64'd1);
        chk("chk_count", {56'd0, la_out[26:19]}, 64'd3);
        chk("chk_busy",  {63'd0, la_out[16]}, 64'd0);

        // A single zero byte gives 16'hE1F0.
        st_w[0] = 32'h00000000; st_nb[0] = 2'd0;
        run_stream(1);
        chk("zero_io", {48'd0, io_out}, 64'h0000_0000_0000_E1F0);

        // A second toggle during shift is held and accepted later.
        begin
            exp_t e;
            e.crc = ref_word(ref_word(16'hFFFF, 32'hDEADBEEF, 2'd3), 32'hC0FFEE00, 2'd2);
            e.cnt = 8'd2;
            sb_q.push_back(e);
            pulse_start();
            set_word(32'hDEADBEEF, 2'd3, 1'b0);
            tick();
            set_word(32'hC0FFEE00, 2'd2, 1'b1);
            wait_ack();
            wait_done();
            chk("dbl_ack",   {63'd0, la_out[18]}, {63'd0, req});
            chk("dbl_count", {56'd0, la_out[26:19]}, 64'd2);
        end

        // Abort a stream with clear, then rerun the check sequence cleanly.
        pulse_start();
        set_word(32'h55AA55AA, 2'd3, 1'b0);
        wait_ack();
        pulse_clear();
        chk("clr_io", {48'd0, io_out}, 64'd0);
        chk("clr_crc", {48'd0, la_out[15:0]}, 64'h0000_0000_0000_FFFF);
        st_w[0] = 32'h31323334; st_nb[0] = 2'd3;
        st_w[1] = 32'h35363738; st_nb[1] = 2'd3;
        st_w[2] = 32'h39000000; st_nb[2] = 2'd0;
        run_stream(3);
        chk("clr_rerun", {48'd0, io_out}, 64'h0000_0000_0000_29B1);

        // Random streams.
        for (int s = 0; s < 25; s++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                st_w[i]  = $urandom;
                st_nb[i] = 2'($urandom_range(0, 3));
            end
            run_stream(n);
        end

        // Asynchronous reset in the middle of a shift.
        pulse_start();
        set_word(32'h12345678, 2'd3, 1'b0);
        wait_ack();
        chk("pre_rst_io", {48'd0, io_out}, 64'h0000_0000_0000_AAAA);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_io", {48'd0, io_out}, 64'd0);
        chk("arst_la", la_out, 64'd0);
        req   = 1'b0;
        la_in = 64'd0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_io", {48'd0, io_out}, 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
